ram_controller: RTL and testbench

Request/response front end for the 2048 x 64-bit `RAM` block. It accepts word read/write requests from the datapath over a valid/ready handshake and buffers them in a 2-entry queue. It sequences each request onto the RAM's `address` / `isReading` / bidirectional `data` bus, and returns read data through a held response register. It sits directly upstream of `RAM` and is the only agent that drives the RAM bus.

---
 rtl/ram_controller.sv | 125 ++++++++++++
 tb/tb_ram_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_controller.sv
// Request/response front end for the 2048 x 64-bit RAM: 2-entry request queue,
// IDLE/WRITE/READ sequencer on the shared bidirectional bus, held read response.
module ram_controller #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [0:DATA_W-1] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [0:DATA_W-1] resp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_is_reading,
  inout  wire  [0:DATA_W-1] ram_data
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [0:DATA_W-1] wdata;
  } req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t            state;
  req_t              q_mem [QDEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [0:DATA_W-1] wdata_q;
  req_t              head;
  logic              push;
  logic              pop;

  assign head      = q_mem[rd_ptr];
  assign req_ready = (count < CW'(QDEPTH));
  assign push      = req_valid && req_ready;
  // Reads wait on the registered resp_valid so a response slot is never
  // reused on the edge that frees it; a blocked read also holds back later writes.
  assign pop       = (state == IDLE) && (count != '0) && (head.write || !resp_valid);
  assign busy      = (count != '0) || (state != IDLE);

  assign ram_data  = ram_is_reading ? {DATA_W{1'bz}} : wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        q_mem[wr_ptr] <= '{write: req_write, addr: req_addr, wdata: req_wdata};
        wr_ptr        <= (wr_ptr == PW'(QDEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(QDEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ram_address    <= '0;
      ram_is_reading <= 1'b1;
      wdata_q        <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
    end else begin
      if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            ram_address <= head.addr;
            if (head.write) begin
              wdata_q        <= head.wdata;
              ram_is_reading <= 1'b0;
              state          <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        WRITE: begin
          ram_is_reading <= 1'b1;
          state          <= IDLE;
        end
        READ: begin
          resp_rdata <= ram_data;
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          ram_is_reading <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_controller.sv
// Bench for ram_controller: behavioural RAM on the shared bus, directed latency /
// backpressure / reset cases, then randomized traffic against an in-order memory model.
module tb_ram_controller;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [0:DATA_W-1] req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [0:DATA_W-1] resp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_is_reading;
  wire  [0:DATA_W-1] ram_data;

  ram_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .QDEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .busy(busy), .ram_address(ram_address), .ram_is_reading(ram_is_reading),
    .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: drives the bus while reading, captures on edges while writing
  logic [0:DATA_W-1] ram_mem [0:2047];
  assign ram_data = ram_is_reading ? ram_mem[ram_address] : {DATA_W{1'bz}};

  // Reference model: memory image and expected responses, updated at acceptance
  logic [0:DATA_W-1] ref_mem [0:2047];
  logic [0:DATA_W-1] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int n_resp = 0;
  int exp_writes = 0;
  int obs_writes = 0;
  int lowrun_err = 0;
  logic prev_low = 1'b0;
  logic rand_rr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!ram_is_reading) ram_mem[ram_address] <= ram_data;
    if (!reset) begin
      if (!ram_is_reading) obs_writes++;
      if (req_valid && req_ready) begin
        if (req_write) begin
          ref_mem[req_addr] = req_wdata;
          exp_writes++;
        end else begin
          exp_q.push_back(ref_mem[req_addr]);
        end
      end
      if (resp_valid && resp_ready) begin
        n_resp++;
        if (exp_q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
        else chk("resp_data", resp_rdata, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (!ram_is_reading && prev_low) lowrun_err++;
      prev_low = !ram_is_reading;
    end else begin
      prev_low = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [0:DATA_W-1] d);
    int n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("accept_timeout", 64'd1, 64'd0);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rand_rr = 1'b0;
    resp_ready = 1'b1;
    while ((exp_q.size() != 0 || busy || resp_valid) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 64'd1, 64'd0);
    resp_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ram_address"}, 64'(ram_address), 64'd0);
    chk({tag, "_ram_is_reading"}, 64'(ram_is_reading), 64'd1);
  endtask

  logic [ADDR_W-1:0] pool [8];
  int nbad;
  int resp_before;

  initial begin
    pool = '{11'd0, 11'd1, 11'd2, 11'd5, 11'd1023, 11'd1024, 11'd2046, 11'd2047};

    // Asynchronous reset, checked between edges
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_async");
    tick(); tick();
    reset = 1'b0;
    tick();

    // Write then read 1024 with cycle-level latency checks
    issue(1'b1, 11'd1024, 64'hff04);
    chk("wr_a0_isrd", 64'(ram_is_reading), 64'd1);
    tick();
    chk("wr_a1_isrd", 64'(ram_is_reading), 64'd0);
    chk("wr_a1_addr", 64'(ram_address), 64'd1024);
    chk("wr_a1_data", ram_data, 64'hff04);
    tick();
    chk("wr_a2_isrd", 64'(ram_is_reading), 64'd1);
    chk("wr_a2_busy", 64'(busy), 64'd0);
    issue(1'b0, 11'd1024, '0);
    chk("rd_b0_valid", 64'(resp_valid), 64'd0);
    tick();
    chk("rd_b1_valid", 64'(resp_valid), 64'd0);
    tick();
    chk("rd_b2_valid", 64'(resp_valid), 64'd1);
    chk("rd_b2_data", resp_rdata, 64'hff04);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("rd_consumed", 64'(resp_valid), 64'd0);
    chk("rd_held_data", resp_rdata, 64'hff04);

    // Neighbour isolation
    issue(1'b1, 11'd1023, 64'h1);
    issue(1'b1, 11'd1024, 64'h2);
    issue(1'b0, 11'd1023, '0);
    issue(1'b0, 11'd1024, '0);
    drain();

    // Backpressure: four reads with resp_ready low
    resp_before = n_resp;
    issue(1'b0, 11'd1023, '0);
    issue(1'b0, 11'd1024, '0);
    issue(1'b0, 11'd1023, '0);
    chk("bp_full_ready", 64'(req_ready), 64'd0);
    chk("bp_resp_held", 64'(resp_valid), 64'd1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 11'd1024;
    tick(); tick(); tick();
    chk("bp_still_full", 64'(req_ready), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    resp_ready = 1'b1;
    issue(1'b0, 11'd1024, '0);
    drain();
    chk("bp_resp_count", 64'(n_resp - resp_before), 64'd4);

    // Reset during WRITE aborts the write and flushes the queue
    issue(1'b1, 11'd5, 64'h7);
    drain();
    issue(1'b1, 11'd5, 64'hdead);
    tick();
    chk("rstw_in_write", 64'(ram_is_reading), 64'd0);
    reset = 1'b1;
    #1 check_reset_outputs("rstw");
    tick();
    reset = 1'b0;
    exp_q.delete();
    ref_mem[5] = 64'h7;
    exp_writes--;
    tick();
    resp_before = n_resp;
    issue(1'b0, 11'd5, '0);
    drain();
    chk("rstw_resp_count", 64'(n_resp - resp_before), 64'd1);
    chk("rstw_readback", resp_rdata, 64'h7);

    // Address boundaries
    issue(1'b1, 11'd0, 64'ha5a5_0000_0000_0001);
    issue(1'b1, 11'd2047, 64'h5a5a_ffff_ffff_fffe);
    issue(1'b0, 11'd0, '0);
    issue(1'b0, 11'd2047, '0);
    drain();
    chk("bnd_last_data", resp_rdata, 64'h5a5a_ffff_ffff_fffe);

    // Randomized traffic over a small address pool
    for (int unsigned i = 0; i < 8; i++) issue(1'b1, pool[i], {$urandom, $urandom});
    rand_rr = 1'b1;
    for (int unsigned i = 0; i < 400; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      issue(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], {$urandom, $urandom});
    end
    drain();

    chk("write_count", 64'(obs_writes), 64'(exp_writes));
    chk("write_single_cycle", 64'(lowrun_err), 64'd0);
    chk("queue_empty_end", 64'(exp_q.size()), 64'd0);
    nbad = 0;
    for (int unsigned i = 0; i < 8; i++) if (ram_mem[pool[i]] !== ref_mem[pool[i]]) nbad++;
    chk("mem_final", 64'(nbad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
